// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants for the MIPS front end
// Instruction field positions, register address width and fetch step.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          RS_MSB     = 25;
  localparam int          RS_LSB     = 21;
  localparam int          RT_MSB     = 20;
  localparam int          RT_LSB     = 16;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use hazard detector
// Flags an ID instruction whose Rs or Rt is the destination of a load in EX.
module load_use_detect
  import mips_pkg::*;
(
  input  logic                  valid_id,
  input  logic [31:0]           instr_id,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  lu
);

  logic [REG_ADDR_W-1:0] rs_id;
  logic [REG_ADDR_W-1:0] rt_id;
  logic                  unused_fields;

  assign rs_id = instr_id[RS_MSB:RS_LSB];
  assign rt_id = instr_id[RT_MSB:RT_LSB];
  assign unused_fields = ^{instr_id[31:26], instr_id[15:0]};

  // $zero is never a real dependency, so a load into r0 never stalls
  assign lu = valid_id & ex_mem_read & (ex_rt != '0) &
              ((ex_rt == rs_id) | (ex_rt == rt_id));

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC, IF/ID register, redirects and load-use stall
// Priority: reset > EX branch > load-use stall > ID jump > sequential fetch.
module if_id_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           instr_if,
  output logic [31:0]           pc,
  input  logic                  jump_id,
  input  logic [31:0]           jump_target_id,
  input  logic                  branch_taken_ex,
  input  logic [31:0]           branch_target_ex,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic [31:0]           instr_id,
  output logic [31:0]           pc4_id,
  output logic                  valid_id,
  output logic                  bubble,
  output logic [15:0]           stall_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic        lu;

  load_use_detect u_lu (
    .valid_id    (valid_q),
    .instr_id    (instr_q),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .lu          (lu)
  );

  assign pc_plus4 = pc_q + PC_STEP;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (branch_taken_ex) begin
      // the branch's younger instructions (in ID and in fetch) are squashed
      pc_d    = branch_target_ex;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else if (lu) begin
      cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
    end else if (jump_id && valid_q) begin
      pc_d    = jump_target_id;
      instr_d = NOP_INSTR;
      pc4_d   = '0;
      valid_d = 1'b0;
    end else begin
      pc_d    = pc_plus4;
      instr_d = instr_if;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      pc4_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc          = pc_q;
  assign instr_id    = instr_q;
  assign pc4_id      = pc4_q;
  assign valid_id    = valid_q;
  assign stall_count = cnt_q;
  assign bubble      = ~rst & (branch_taken_ex | lu | ~valid_q);

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - self-checking bench for if_id_stage
// Randomized and directed stimulus checked against a cycle-level behavioural model.
module tb_if_id_stage;

  localparam logic [31:0] RST_PC  = 32'h0040_0000;
  localparam logic [31:0] ADD_INS = 32'h0102_4820; // add $9,$8,$2

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_if;
  logic [31:0] pc;
  logic        jump_id;
  logic [31:0] jump_target_id;
  logic        branch_taken_ex;
  logic [31:0] branch_target_ex;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic [31:0] instr_id;
  logic [31:0] pc4_id;
  logic        valid_id;
  logic        bubble;
  logic [15:0] stall_count;

  logic        force_en;
  logic [31:0] instr_force;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[7:2], 1'b0, a[5:2] ^ 4'h3, 1'b0, a[9:6], a[15:0] ^ a[31:16]};
  endfunction

  assign instr_if = force_en ? instr_force : imem(pc);

  if_id_stage #(.RESET_PC(RST_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_if         (instr_if),
    .pc               (pc),
    .jump_id          (jump_id),
    .jump_target_id   (jump_target_id),
    .branch_taken_ex  (branch_taken_ex),
    .branch_target_ex (branch_target_ex),
    .ex_mem_read      (ex_mem_read),
    .ex_rt            (ex_rt),
    .instr_id         (instr_id),
    .pc4_id           (pc4_id),
    .valid_id         (valid_id),
    .bubble           (bubble),
    .stall_count      (stall_count)
  );

  function automatic bit model_lu();
    int rs_f, rt_f, d;
    rs_f = int'((m_instr >> 21) & 32'd31);
    rt_f = int'((m_instr >> 16) & 32'd31);
    d    = int'(ex_rt);
    return m_valid && ex_mem_read && d != 0 && (d == rs_f || d == rt_f);
  endfunction

  function automatic bit model_bubble();
    if (rst) return 1'b0;
    return branch_taken_ex || model_lu() || !m_valid;
  endfunction

  // advance one clock; the model computes its next state from the pre-edge inputs
  task automatic step();
    logic [31:0] n_pc, n_instr, n_pc4, fetched;
    logic        n_valid;
    int          n_cnt;
    fetched = force_en ? instr_force : imem(m_pc);
    n_pc = m_pc; n_instr = m_instr; n_pc4 = m_pc4; n_valid = m_valid; n_cnt = m_cnt;
    if (rst) begin
      n_pc = RST_PC; n_instr = 0; n_pc4 = 0; n_valid = 0; n_cnt = 0;
    end else if (branch_taken_ex) begin
      n_pc = branch_target_ex; n_instr = 0; n_valid = 0;
    end else if (model_lu()) begin
      n_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    end else if (jump_id && m_valid) begin
      n_pc = jump_target_id; n_instr = 0; n_valid = 0;
    end else begin
      n_pc = m_pc + 32'd4; n_instr = fetched; n_pc4 = m_pc + 32'd4; n_valid = 1;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_instr = n_instr; m_pc4 = n_pc4; m_valid = n_valid; m_cnt = n_cnt;
  endtask

  task automatic clear_inputs();
    jump_id = 0; jump_target_id = 0; branch_taken_ex = 0; branch_target_ex = 0;
    ex_mem_read = 0; ex_rt = 0; force_en = 0; instr_force = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    m_pc = 32'hDEAD_BEEF; m_instr = 32'hDEAD_BEEF; m_pc4 = 0; m_valid = 1; m_cnt = 0;
    step(); step();
    n_tests++; if (pc !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
    n_tests++; if (valid_id !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_id); end
    n_tests++; if (instr_id !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr_id); end
    n_tests++; if (stall_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0", stall_count); end
    n_tests++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble_in_rst got %b want 0", bubble); end
    rst = 0; #1;
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL reset_bubble_after got %b want 1", bubble); end
    for (int k = 0; k < 3; k++) begin
      logic [31:0] exp_pc;
      exp_pc = RST_PC + 32'(4 * k);
      n_tests++; if (pc !== exp_pc) begin n_fail++; $display("FAIL reset_seq_pc%0d got %h want %h", k, pc, exp_pc); end
      step();
      n_tests++; if (instr_id !== imem(exp_pc) || valid_id !== 1'b1) begin
        n_fail++; $display("FAIL reset_seq_id%0d got %h/%b want %h/1", k, instr_id, valid_id, imem(exp_pc));
      end
    end
  endtask

  task automatic test_load_use();
    logic [31:0] held_pc;
    clear_inputs();
    force_en = 1; instr_force = ADD_INS;
    step();
    force_en = 0;
    held_pc = pc;
    ex_mem_read = 1; ex_rt = 5'd8; #1;
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL lu_bubble got %b want 1", bubble); end
    step();
    n_tests++; if (pc !== held_pc || instr_id !== ADD_INS) begin
      n_fail++; $display("FAIL lu_hold got %h/%h want %h/%h", pc, instr_id, held_pc, ADD_INS);
    end
    n_tests++; if (stall_count !== 16'd1) begin n_fail++; $display("FAIL lu_count got %0d want 1", stall_count); end
    ex_rt = 5'd0; #1;
    n_tests++; if (bubble !== 1'b0) begin n_fail++; $display("FAIL lu_r0_bubble got %b want 0", bubble); end
    step();
    n_tests++; if (pc !== held_pc + 32'd4 || stall_count !== 16'd1) begin
      n_fail++; $display("FAIL lu_r0_advance got %h/%0d want %h/1", pc, stall_count, held_pc + 32'd4);
    end
    clear_inputs();
  endtask

  task automatic test_branch_priority();
    clear_inputs();
    force_en = 1; instr_force = ADD_INS;
    step();
    force_en = 0;
    ex_mem_read = 1; ex_rt = 5'd8;
    jump_id = 1; jump_target_id = 32'h2000;
    branch_taken_ex = 1; branch_target_ex = 32'h100; #1;
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL br_bubble got %b want 1", bubble); end
    step();
    clear_inputs(); #1;
    n_tests++; if (pc !== 32'h100 || valid_id !== 1'b0) begin
      n_fail++; $display("FAIL br_redirect got %h/%b want 00000100/0", pc, valid_id);
    end
    n_tests++; if (int'(stall_count) !== m_cnt || bubble !== 1'b1) begin
      n_fail++; $display("FAIL br_no_stall got %0d/%b want %0d/1", stall_count, bubble, m_cnt);
    end
  endtask

  task automatic test_jump();
    logic [31:0] exp_pc;
    clear_inputs();
    step();
    jump_id = 1; jump_target_id = 32'h2000;
    step();
    n_tests++; if (pc !== 32'h2000 || instr_id !== 32'h0 || valid_id !== 1'b0) begin
      n_fail++; $display("FAIL jump_taken got %h/%h/%b want 00002000/0/0", pc, instr_id, valid_id);
    end
    jump_target_id = 32'h3000;
    step();
    exp_pc = 32'h2004;
    n_tests++; if (pc !== exp_pc || valid_id !== 1'b1) begin
      n_fail++; $display("FAIL jump_ignored got %h/%b want %h/1", pc, valid_id, exp_pc);
    end
    clear_inputs();
  endtask

  task automatic test_wrap();
    clear_inputs();
    branch_taken_ex = 1; branch_target_ex = 32'hFFFF_FFFC;
    step();
    clear_inputs();
    n_tests++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup got %h want fffffffc", pc); end
    step();
    n_tests++; if (pc !== 32'h0 || pc4_id !== 32'h0 || valid_id !== 1'b1) begin
      n_fail++; $display("FAIL wrap got %h/%h/%b want 0/0/1", pc, pc4_id, valid_id);
    end
    n_tests++; if (instr_id !== imem(32'hFFFF_FFFC)) begin
      n_fail++; $display("FAIL wrap_instr got %h want %h", instr_id, imem(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_random();
    clear_inputs();
    for (int i = 0; i < 2000; i++) begin
      rst              = ($urandom_range(63) == 0);
      branch_taken_ex  = ($urandom_range(7) == 0);
      branch_target_ex = $urandom;
      jump_id          = ($urandom_range(5) == 0);
      jump_target_id   = $urandom;
      ex_mem_read      = ($urandom_range(2) == 0);
      ex_rt            = 5'($urandom_range(15));
      #1;
      n_tests++; if (bubble !== model_bubble()) begin
        n_fail++; $display("FAIL rnd_bubble cyc %0d got %b want %b", i, bubble, model_bubble());
      end
      step();
      n_tests++; if (pc !== m_pc || valid_id !== m_valid || instr_id !== m_instr) begin
        n_fail++; $display("FAIL rnd_state cyc %0d got %h/%b/%h want %h/%b/%h",
                           i, pc, valid_id, instr_id, m_pc, m_valid, m_instr);
      end
      n_tests++; if (int'(stall_count) !== m_cnt || (m_valid && pc4_id !== m_pc4)) begin
        n_fail++; $display("FAIL rnd_cnt_pc4 cyc %0d got %0d/%h want %0d/%h", i, stall_count, pc4_id, m_cnt, m_pc4);
      end
    end
    rst = 0; clear_inputs();
  endtask

  task automatic test_saturate();
    logic [31:0] held_pc;
    clear_inputs();
    force_en = 1; instr_force = ADD_INS;
    step();
    force_en = 0;
    held_pc = pc;
    ex_mem_read = 1; ex_rt = 5'd8;
    for (int i = 0; i < 70000; i++) step();
    n_tests++; if (stall_count !== 16'hFFFF || int'(stall_count) !== m_cnt) begin
      n_fail++; $display("FAIL sat_count got %h want ffff", stall_count);
    end
    n_tests++; if (pc !== held_pc || bubble !== 1'b1) begin
      n_fail++; $display("FAIL sat_hold got %h/%b want %h/1", pc, bubble, held_pc);
    end
    rst = 1;
    step();
    n_tests++; if (stall_count !== 16'h0 || pc !== RST_PC || valid_id !== 1'b0) begin
      n_fail++; $display("FAIL sat_reset got %h/%h/%b want 0/%h/0", stall_count, pc, valid_id, RST_PC);
    end
    rst = 0; #1;
    n_tests++; if (bubble !== 1'b1) begin n_fail++; $display("FAIL sat_reset_bubble got %b want 1", bubble); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_priority();
    test_jump();
    test_wrap();
    test_random();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
